regfile_nrp: RTL and testbench

REGFILE_NRP -- requirements
Module: regfile_nrp

---
 rtl/regfile_nrp.sv | 92 +++++++++
 tb/tb_regfile_nrp.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_nrp.sv
// regfile_nrp: parametric register file with one write port and NRD registered read ports.
// Optional macro REGFILE_BYPASS_EN selects write-first collision handling (read-first otherwise).
`default_nettype none

//------------------------------------------------------------------------------
// Module   : regfile_nrp
// Function : DEPTH x WIDTH register file, 1 write port, NRD read ports with
//            1-cycle registered read data and per-port valid flags.
//            Macro REGFILE_BYPASS_EN: same-edge read/write to one index returns
//            the new write data; undefined returns the old contents.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module regfile_nrp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 WrEn,
  input  logic [AW-1:0]        WrAddr,
  input  logic [WIDTH-1:0]     WrData,
  input  logic [NRD-1:0]       RdEn,
  input  logic [NRD*AW-1:0]    RdSel,
  output logic [NRD*WIDTH-1:0] RdData,
  output logic [NRD-1:0]       RdValid
);

  // One extra bit so DEPTH == 2**AW is representable in the range compare.
  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_ok;

  assign w_wr_ok = WrEn && ({1'b0, WrAddr} < c_DEPTH) &&
                   !((ZERO_REG != 0) && (WrAddr == '0));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[WrAddr] <= WrData;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]    w_sel;
    logic             w_sel_ok;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_data;
    logic             r_vld;

    assign w_sel    = RdSel[gi*AW +: AW];
    assign w_sel_ok = ({1'b0, w_sel} < c_DEPTH) &&
                      !((ZERO_REG != 0) && (w_sel == '0));

    always_comb begin
      w_word = '0;
      if (w_sel_ok) begin
        w_word = r_mem[w_sel];
      end
`ifdef REGFILE_BYPASS_EN
      // w_wr_ok already excludes out-of-range and suppressed zero-register writes.
      if (w_wr_ok && (WrAddr == w_sel)) begin
        w_word = WrData;
      end
`endif
    end

    always_ff @(posedge Clk) begin
      if (Rst) begin
        r_data <= '0;
        r_vld  <= 1'b0;
      end else begin
        r_vld <= RdEn[gi];
        if (RdEn[gi]) begin
          r_data <= w_word;
        end
      end
    end

    assign RdData[gi*WIDTH +: WIDTH] = r_data;
    assign RdValid[gi]               = r_vld;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_nrp.sv
// tb_regfile_nrp: directed + randomized scoreboard bench for regfile_nrp (default and 16x20 builds).
`default_nettype none

module tb_regfile_nrp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst;
  // unit A: default parameters (32x32, 2 read ports, ZERO_REG=1)
  logic        a_we;
  logic [4:0]  a_wa;
  logic [31:0] a_wd;
  logic [1:0]  a_re;
  logic [9:0]  a_rs;
  logic [63:0] a_rd;
  logic [1:0]  a_rv;
  // unit B: WIDTH=16, DEPTH=20, 1 read port, ZERO_REG=0
  logic        b_we;
  logic [4:0]  b_wa;
  logic [15:0] b_wd;
  logic [0:0]  b_re;
  logic [4:0]  b_rs;
  logic [15:0] b_rd;
  logic [0:0]  b_rv;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int          unit;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl[32];

  always #5 Clk = ~Clk;

  regfile_nrp u_a (
    .Clk(Clk), .Rst(Rst), .WrEn(a_we), .WrAddr(a_wa), .WrData(a_wd),
    .RdEn(a_re), .RdSel(a_rs), .RdData(a_rd), .RdValid(a_rv)
  );

  regfile_nrp #(.WIDTH(16), .DEPTH(20), .AW(5), .NRD(1), .ZERO_REG(0)) u_b (
    .Clk(Clk), .Rst(Rst), .WrEn(b_we), .WrAddr(b_wa), .WrData(b_wd),
    .RdEn(b_re), .RdSel(b_rs), .RdData(b_rd), .RdValid(b_rv)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int unit, input logic [31:0] data, input string tag);
    exp_t e;
    e.unit = unit;
    e.data = data;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // One clock edge; checks valid flags, then drains the scoreboard.
  task automatic tick();
    logic [1:0]  ea;
    logic        eb;
    logic        rr;
    logic [31:0] obs;
    exp_t        e;
    ea = a_re;
    eb = b_re[0];
    rr = Rst;
    @(posedge Clk);
    #1;
    chk("a_valid", {30'b0, a_rv}, {30'b0, (rr ? 2'b00 : ea)});
    chk("b_valid", {31'b0, b_rv}, {31'b0, (eb & ~rr)});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.unit)
        0:       obs = a_rd[31:0];
        1:       obs = a_rd[63:32];
        default: obs = {16'b0, b_rd};
      endcase
      chk(e.tag, obs, e.data);
    end
  endtask

  task automatic a_write(input logic [4:0] ad, input logic [31:0] d);
    a_we = 1'b1;
    a_wa = ad;
    a_wd = d;
    tick();
    a_we = 1'b0;
    if (ad != 5'd0) mdl[ad] = d;
  endtask

  task automatic a_read(input logic [4:0] s0, input logic [31:0] e0,
                        input logic [4:0] s1, input logic [31:0] e1,
                        input logic [1:0] en, input string tag);
    a_re = en;
    a_rs = {s1, s0};
    if (en[0]) push(0, e0, {tag, "_p0"});
    if (en[1]) push(1, e1, {tag, "_p1"});
    tick();
    a_re = 2'b00;
  endtask

  task automatic b_write(input logic [4:0] ad, input logic [15:0] d);
    b_we = 1'b1;
    b_wa = ad;
    b_wd = d;
    tick();
    b_we = 1'b0;
  endtask

  task automatic b_read(input logic [4:0] s, input logic [15:0] e, input string tag);
    b_re = 1'b1;
    b_rs = s;
    push(2, {16'b0, e}, tag);
    tick();
    b_re = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  wa, s0, s1;
    logic [31:0] wd, e0, e1;

    Rst  = 1'b1;
    a_we = 1'b0; a_wa = '0; a_wd = '0; a_re = '0; a_rs = '0;
    b_we = 1'b0; b_wa = '0; b_wd = '0; b_re = '0; b_rs = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    tick();
    tick();
    chk("reset_a_data", a_rd[31:0] | a_rd[63:32], 32'h0);
    chk("reset_b_data", {16'b0, b_rd}, 32'h0);
    Rst = 1'b0;

    // Reset clears storage; reset also beats a simultaneous write and read.
    a_write(5'd5, 32'hDEADBEEF);
    a_read(5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b01, "pre_reset");
    Rst  = 1'b1;
    a_we = 1'b1; a_wa = 5'd6; a_wd = 32'h11111111;
    a_re = 2'b11; a_rs = {5'd6, 5'd5};
    tick();
    a_we = 1'b0; a_re = 2'b00;
    chk("rst_prio_data", a_rd[31:0], 32'h0);
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    Rst = 1'b0;
    a_read(5'd5, 32'h0, 5'd6, 32'h0, 2'b11, "post_reset");

    // Top register and zero register read on the same cycle.
    a_write(5'd31, 32'h12345678);
    a_read(5'd31, 32'h12345678, 5'd0, 32'h0, 2'b11, "r31_r0");

    // Writes to register 0 are dropped.
    a_write(5'd0, 32'hFFFFFFFF);
    a_read(5'd0, 32'h0, 5'd0, 32'h0, 2'b11, "zero_reg");

    // Same-edge read and write collision.
    a_write(5'd7, 32'h00000001);
    a_we = 1'b1; a_wa = 5'd7; a_wd = 32'h000000AA;
    a_re = 2'b11; a_rs = {5'd7, 5'd7};
    push(0, BYP ? 32'h000000AA : 32'h00000001, "collide_p0");
    push(1, BYP ? 32'h000000AA : 32'h00000001, "collide_p1");
    tick();
    a_we = 1'b0; a_re = 2'b00;
    mdl[7] = 32'h000000AA;
    a_read(5'd7, 32'hAA, 5'd7, 32'hAA, 2'b11, "after_collide");

    // Read data holds while RdEn is low even as the register changes.
    a_write(5'd9, 32'h00000055);
    a_read(5'd0, 32'h0, 5'd9, 32'h55, 2'b10, "hold_setup");
    a_write(5'd9, 32'h00000066);
    chk("hold_p1", a_rd[63:32], 32'h00000055);
    tick();
    chk("hold_p1_idle", a_rd[63:32], 32'h00000055);
    a_read(5'd9, 32'h66, 5'd9, 32'h66, 2'b11, "new_value");

    // Randomized write+dual-read traffic against the reference array.
    for (int n = 0; n < 24; n++) begin
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      s0 = (n % 4 == 0) ? wa : 5'($urandom_range(0, 31));
      s1 = 5'($urandom_range(0, 31));
      e0 = (BYP && s0 == wa && wa != 5'd0) ? wd : mdl[s0];
      e1 = (BYP && s1 == wa && wa != 5'd0) ? wd : mdl[s1];
      a_we = 1'b1; a_wa = wa; a_wd = wd;
      a_read(s0, e0, s1, e1, 2'b11, "rand");
      a_we = 1'b0;
      if (wa != 5'd0) mdl[wa] = wd;
    end

    // 16-bit x 20 unit: out-of-range write and read, every entry intact.
    for (int i = 0; i < 20; i++) b_write(5'(i), 16'(i * 16'h0111 + 16'h1000));
    b_write(5'd25, 16'hBEEF);
    b_read(5'd25, 16'h0000, "b_oob_read");
    for (int i = 0; i < 20; i++) b_read(5'(i), 16'(i * 16'h0111 + 16'h1000), "b_entry");

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
